vc_input_buffer: RTL and testbench
==================================

// Module: vc_input_buffer
// PURPOSE
//   Multi-virtual-channel input buffer for one router input port. NUM_VC independent circular
//   FIFOs; each lane holds up to DEPTH flits of DATA_WIDTH bits. One push and one pop per cycle,
//   each addressed to a VC. Exposes every lane's head flit so the route/VC allocator can inspect
//   all heads at once. Adds per-lane occupancy, an almost-full threshold and sticky
//   overflow/underflow error flags.
// PARAMETERS
//   NUM_VC      2   number of virtual channels (>=1)
//   DEPTH       3   flits per lane (>=2, need not be a power of two)
//   DATA_WIDTH  32  flit width in bits
//   AF_LEVEL    2   almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   Localparams: VC_BITS = max(1,$clog2(NUM_VC)), PTR_BITS = max(1,$clog2(DEPTH)),
//   CNT_BITS = $clog2(DEPTH+1)
// PORTS
//   clk          in   1                    clock; all state updates on its rising edge
//   reset        in   1                    synchronous, active-high
//   push         in   1                    write request
//   push_vc      in   VC_BITS              target lane for push
//   din          in   DATA_WIDTH           flit to write
//   pop          in   1                    read request
//   pop_vc       in   VC_BITS              lane to pop
//   head         out  NUM_VC*DATA_WIDTH    lane v head flit at [v*DATA_WIDTH +: DATA_WIDTH]
//   empty        out  NUM_VC               per-lane empty
//   full         out  NUM_VC               per-lane full (count == DEPTH)
//   almost_full  out  NUM_VC               per-lane count >= AF_LEVEL
//   count        out  NUM_VC*CNT_BITS      per-lane occupancy
//   overflow     out  1                    sticky: push to a full lane without a same-lane pop
//   underflow    out  1                    sticky: pop of an empty lane
// BEHAVIOUR
//   - Reset, synchronous and active-high, is sampled on the clk edge. It clears all pointers,
//     all counts, all storage and both error flags. The same edge takes effect mid-burst and
//     discards any push/pop in that cycle. After reset: empty = all ones, full = 0,
//     almost_full = 0, count = 0, head = 0, overflow = 0, underflow = 0.
//   - Write: an accepted push stores din at the lane's write pointer at the clk edge.
//     The flit is visible on head no earlier than the next cycle. There is no bypass:
//     a push to an empty lane is never poppable in the same cycle.
//   - Read: head is combinational from the lane's read pointer. An accepted pop advances the
//     read pointer at the edge, and the next flit is visible in the following cycle.
//   - Pointers wrap from DEPTH-1 to 0. This is an explicit compare, not a power-of-two mask.
//   - Acceptance, per cycle, with pv = pop_vc and wv = push_vc:
//       pop accepted  iff pop & ~empty[pv]
//       push accepted iff push & (~full[wv] | (pop & pv == wv))
//     A full lane accepts push plus pop in the same cycle, and its count stays DEPTH.
//     An empty lane given push plus pop: push is accepted, pop is ignored and flagged.
//     Push and pop to different lanes are fully independent.
//   - count[v] changes by +1, -1 or 0 per cycle. It never exceeds DEPTH and never wraps below 0.
//   - A rejected push leaves storage and pointers untouched and sets overflow.
//     A rejected pop sets underflow. Both flags hold until reset.
//   - push_vc/pop_vc >= NUM_VC (non-power-of-two NUM_VC): request ignored; flag set as
//     overflow (push) or underflow (pop).
//   - empty, full and almost_full are decoded from count and are combinational.
// STRUCTURE
//   - Package router_pkg: flit width default, VC_BITS/CNT_BITS helper functions, and
//     typedef vc_id_t.
//   - Sub-module vc_fifo_lane: one circular lane with parameters DEPTH, DATA_WIDTH and AF_LEVEL.
//     Ports: clk, reset, wr_en, rd_en, din, dout, count, empty, full, almost_full.
//   - Top level: instantiates NUM_VC lanes with a generate loop, decodes the per-lane
//     wr_en/rd_en from the acceptance rules, packs the outputs, and holds the error flags.
// TESTING
//   1. Reset, then push 0xA1,0xA2,0xA3 to VC0 -> full[0]=1, count VC0=3, almost_full[0]=1
//      after the 2nd push; VC1 stays empty.
//   2. Pop VC0 three times -> head VC0 shows 0xA1,0xA2,0xA3 in order; empty[0]=1; underflow=0.
//   3. Fill VC1 (0xB1..0xB3), then push 0xB4 together with pop VC1 -> count stays 3;
//      next heads are 0xB2,0xB3,0xB4 (pointer wrap at DEPTH=3).
//   4. Push 0xC1 to full VC1 with no pop -> overflow=1, contents unchanged;
//      pop empty VC0 -> underflow=1.
//   5. Same-cycle push VC0 = 0xD1 and pop VC1 -> both accepted; count VC0 +1, VC1 -1.
//   6. Assert reset with VC0 partially full and push active -> next cycle all empty,
//      count = 0, head = 0, flags = 0.

Source files
------------

// File: rtl/vc_input_buffer_pkg.sv
// Shared router definitions: flit width default, width helpers and the VC id type.
package router_pkg;

    localparam int FLIT_WIDTH     = 32;
    localparam int DEFAULT_NUM_VC = 2;

    function automatic int vc_bits(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic [vc_bits(DEFAULT_NUM_VC)-1:0] vc_id_t;

endpackage

// File: rtl/vc_input_buffer_if.sv
// Push/pop request bus and per-lane status outputs of the VC input buffer.
interface vc_input_buffer_if #(
    parameter int NUM_VC     = 2,
    parameter int DEPTH      = 3,
    parameter int DATA_WIDTH = router_pkg::FLIT_WIDTH
);
    localparam int VC_BITS  = router_pkg::vc_bits(NUM_VC);
    localparam int CNT_BITS = router_pkg::cnt_bits(DEPTH);

    logic                         push;
    logic [VC_BITS-1:0]           push_vc;
    logic [DATA_WIDTH-1:0]        din;
    logic                         pop;
    logic [VC_BITS-1:0]           pop_vc;
    logic [NUM_VC*DATA_WIDTH-1:0] head;
    logic [NUM_VC-1:0]            empty;
    logic [NUM_VC-1:0]            full;
    logic [NUM_VC-1:0]            almost_full;
    logic [NUM_VC*CNT_BITS-1:0]   count;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output push, push_vc, din, pop, pop_vc,
        input  head, empty, full, almost_full, count, overflow, underflow
    );

    modport slave (
        input  push, push_vc, din, pop, pop_vc,
        output head, empty, full, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/vc_input_buffer_lane.sv
// One circular flit lane; callers guarantee wr_en only when there is room
// (or a same-cycle rd_en) and rd_en only when non-empty.
module vc_fifo_lane
    import router_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int AF_LEVEL   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic                           rd_en,
    input  logic [DATA_WIDTH-1:0]          din,
    output logic [DATA_WIDTH-1:0]          dout,
    output logic [cnt_bits(DEPTH)-1:0]     count,
    output logic                           empty,
    output logic                           full,
    output logic                           almost_full
);
    localparam int PTR_BITS = ptr_bits(DEPTH);
    localparam int CNT_BITS = cnt_bits(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_BITS-1:0]   r_wr_ptr;
    logic [PTR_BITS-1:0]   r_rd_ptr;
    logic [CNT_BITS-1:0]   r_count;

    // Explicit wrap so non-power-of-two depths stay correct.
    function automatic logic [PTR_BITS-1:0] next_ptr(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (rd_en) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (wr_en && !rd_en) begin
                r_count <= r_count + 1'b1;
            end else if (rd_en && !wr_en) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign dout        = r_mem[r_rd_ptr];
    assign count       = r_count;
    assign empty       = (r_count == '0);
    assign full        = (r_count == CNT_BITS'(DEPTH));
    assign almost_full = (r_count >= CNT_BITS'(AF_LEVEL));

endmodule

// File: rtl/vc_input_buffer.sv
// Multi-VC input buffer: NUM_VC independent lanes, one push and one pop per cycle,
// all lane heads exposed, sticky overflow/underflow flags.
module vc_input_buffer
    import router_pkg::*;
#(
    parameter int NUM_VC     = 2,
    parameter int DEPTH      = 3,
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int AF_LEVEL   = 2
) (
    input  logic              clk,
    input  logic              reset,
    vc_input_buffer_if.slave  vc_bus
);
    localparam int VC_BITS  = vc_bits(NUM_VC);
    localparam int CNT_BITS = cnt_bits(DEPTH);

    logic [NUM_VC-1:0] w_wr_en;
    logic [NUM_VC-1:0] w_rd_en;
    logic [NUM_VC-1:0] w_empty;
    logic [NUM_VC-1:0] w_full;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic              r_overflow;
    logic              r_underflow;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VC; gi++) begin : g_lane
            logic w_push_sel;
            logic w_pop_sel;

            // Out-of-range VC ids match no lane, so they fall through to the error flags.
            assign w_push_sel  = vc_bus.push && (vc_bus.push_vc == VC_BITS'(gi));
            assign w_pop_sel   = vc_bus.pop  && (vc_bus.pop_vc  == VC_BITS'(gi));
            assign w_rd_en[gi] = w_pop_sel && !w_empty[gi];
            assign w_wr_en[gi] = w_push_sel && (!w_full[gi] || w_pop_sel);

            vc_fifo_lane #(
                .DEPTH      (DEPTH),
                .DATA_WIDTH (DATA_WIDTH),
                .AF_LEVEL   (AF_LEVEL)
            ) u_lane (
                .clk         (clk),
                .reset       (reset),
                .wr_en       (w_wr_en[gi]),
                .rd_en       (w_rd_en[gi]),
                .din         (vc_bus.din),
                .dout        (vc_bus.head[gi*DATA_WIDTH +: DATA_WIDTH]),
                .count       (vc_bus.count[gi*CNT_BITS +: CNT_BITS]),
                .empty       (w_empty[gi]),
                .full        (w_full[gi]),
                .almost_full (vc_bus.almost_full[gi])
            );
        end
    endgenerate

    assign w_push_ok = |w_wr_en;
    assign w_pop_ok  = |w_rd_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (vc_bus.push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (vc_bus.pop && !w_pop_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign vc_bus.empty     = w_empty;
    assign vc_bus.full      = w_full;
    assign vc_bus.overflow  = r_overflow;
    assign vc_bus.underflow = r_underflow;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed checks of the VC input buffer with hand-computed expectations.
module tb_vc_input_buffer;
    import router_pkg::*;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    vc_input_buffer_if #(.NUM_VC(2), .DEPTH(3), .DATA_WIDTH(32)) bus ();

    vc_input_buffer #(
        .NUM_VC     (2),
        .DEPTH      (3),
        .DATA_WIDTH (32),
        .AF_LEVEL   (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .vc_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // One clock of stimulus; outputs are then sampled 1 time unit after the edge.
    task automatic step(input logic ps, input vc_id_t pv, input logic [31:0] d,
                        input logic pp, input vc_id_t qv);
        bus.push    = ps;
        bus.push_vc = pv;
        bus.din     = d;
        bus.pop     = pp;
        bus.pop_vc  = qv;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    function automatic logic [31:0] head_of(input int v);
        return bus.head[v*32 +: 32];
    endfunction

    function automatic logic [31:0] cnt_of(input int v);
        return 32'(bus.count[v*2 +: 2]);
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, " empty"},     32'(bus.empty), 32'h3);
        chk({tag, " full"},      32'(bus.full), 32'h0);
        chk({tag, " af"},        32'(bus.almost_full), 32'h0);
        chk({tag, " count"},     32'(bus.count), 32'h0);
        chk({tag, " head"},      32'(bus.head[31:0]) | 32'(bus.head[63:32]), 32'h0);
        chk({tag, " overflow"},  32'(bus.overflow), 32'h0);
        chk({tag, " underflow"}, 32'(bus.underflow), 32'h0);
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        bus.push    = 1'b0;
        bus.push_vc = '0;
        bus.din     = '0;
        bus.pop     = 1'b0;
        bus.pop_vc  = '0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_idle("reset");

        // Fill VC0.
        step(1, 0, 32'hA1, 0, 0);
        chk("t1 cnt0 after1", cnt_of(0), 1);
        chk("t1 af0 after1", 32'(bus.almost_full[0]), 0);
        step(1, 0, 32'hA2, 0, 0);
        chk("t1 af0 after2", 32'(bus.almost_full[0]), 1);
        chk("t1 full0 after2", 32'(bus.full[0]), 0);
        step(1, 0, 32'hA3, 0, 0);
        chk("t1 full0", 32'(bus.full[0]), 1);
        chk("t1 cnt0", cnt_of(0), 3);
        chk("t1 empty1", 32'(bus.empty[1]), 1);
        chk("t1 cnt1", cnt_of(1), 0);

        // Drain VC0 in order.
        chk("t2 head0 a", head_of(0), 32'hA1);
        step(0, 0, 0, 1, 0);
        chk("t2 head0 b", head_of(0), 32'hA2);
        step(0, 0, 0, 1, 0);
        chk("t2 head0 c", head_of(0), 32'hA3);
        step(0, 0, 0, 1, 0);
        chk("t2 empty0", 32'(bus.empty[0]), 1);
        chk("t2 underflow", 32'(bus.underflow), 0);

        // Fill VC1, then push+pop on the full lane (write pointer wraps).
        step(1, 1, 32'hB1, 0, 0);
        step(1, 1, 32'hB2, 0, 0);
        step(1, 1, 32'hB3, 0, 0);
        chk("t3 full1", 32'(bus.full[1]), 1);
        step(1, 1, 32'hB4, 1, 1);
        chk("t3 cnt1 pushpop", cnt_of(1), 3);
        chk("t3 head1 b2", head_of(1), 32'hB2);
        chk("t3 overflow", 32'(bus.overflow), 0);

        // Push to a full lane without pop is rejected.
        step(1, 1, 32'hC1, 0, 0);
        chk("t4 overflow", 32'(bus.overflow), 1);
        chk("t4 cnt1", cnt_of(1), 3);
        chk("t4 head1", head_of(1), 32'hB2);
        step(0, 0, 0, 1, 1);
        chk("t4 head1 b3", head_of(1), 32'hB3);
        step(0, 0, 0, 1, 1);
        chk("t4 head1 b4", head_of(1), 32'hB4);
        chk("t4 cnt1 after pops", cnt_of(1), 1);
        chk("t4 underflow pre", 32'(bus.underflow), 0);
        step(0, 0, 0, 1, 0);
        chk("t4 underflow", 32'(bus.underflow), 1);
        chk("t4 cnt0", cnt_of(0), 0);

        // Independent push/pop on different lanes.
        step(1, 0, 32'hD1, 1, 1);
        chk("t5 cnt0", cnt_of(0), 1);
        chk("t5 cnt1", cnt_of(1), 0);
        chk("t5 head0", head_of(0), 32'hD1);
        chk("t5 empty", 32'(bus.empty), 32'h2);

        // Reset wins over an active push.
        step(1, 0, 32'hD2, 0, 0);
        chk("t6 cnt0 pre", cnt_of(0), 2);
        reset = 1'b1;
        step(1, 0, 32'hD3, 0, 0);
        reset = 1'b0;
        chk_idle("t6 reset");
        step(0, 0, 0, 0, 0);
        chk("t6 cnt0 post", cnt_of(0), 0);

        // Push+pop to an empty lane: push taken, pop flagged.
        step(1, 0, 32'hE1, 1, 0);
        chk("t7 cnt0", cnt_of(0), 1);
        chk("t7 head0", head_of(0), 32'hE1);
        chk("t7 underflow", 32'(bus.underflow), 1);
        chk("t7 overflow", 32'(bus.overflow), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
